// File: rtl/ysyx_23060184_defines_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060184_defines
// Shared definitions for the write-back result selection path:
//   - RESULT_SRC_* select codes (PC, ALU, MEM, CSR)
//   - result stage state encoding
//   - default data width
// ----------------------------------------------------------------------------
package ysyx_23060184_defines;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Select codes for the write-back result source.
    localparam int RESULT_SRC_PC  = 0;
    localparam int RESULT_SRC_ALU = 1;
    localparam int RESULT_SRC_MEM = 2;
    localparam int RESULT_SRC_CSR = 3;

    // Result stage states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_FULL     = 2'd2
    } result_state_t;

endpackage

// File: rtl/ysyx_23060184_mux_n.sv
// ----------------------------------------------------------------------------
// ysyx_23060184_mux_n
// Combinational N-way mux over a flat bus. Entry i lives at
// data_flat[i*DATA_WIDTH +: DATA_WIDTH]. A key with no matching entry
// (key >= N) yields zero data and raises miss.
// Ports:
//   key        in   KEY_WIDTH       entry index
//   data_flat  in   N*DATA_WIDTH    packed entries
//   data_out   out  DATA_WIDTH      selected entry, 0 on miss
//   miss       out  1               key does not address any entry
// ----------------------------------------------------------------------------
module ysyx_23060184_mux_n #(
    parameter int N          = 4,
    parameter int KEY_WIDTH  = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic [KEY_WIDTH-1:0]    key,
    input  logic [N*DATA_WIDTH-1:0] data_flat,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    miss
);

    // One-hot AND-OR selection; no entry matches an out-of-range key.
    always_comb begin
        data_out = '0;
        miss     = 1'b1;
        for (int i = 0; i < N; i++) begin
            data_out = data_out
                     | (data_flat[i*DATA_WIDTH +: DATA_WIDTH]
                        & {DATA_WIDTH{int'(key) == i}});
            miss     = miss & ~(int'(key) == i);
        end
    end

endmodule

// File: rtl/ysyx_23060184_result_sel_stage.sv
// ----------------------------------------------------------------------------
// ysyx_23060184_result_sel_stage
// Registered write-back result selector between EXU/LSU and the register
// file. Selects one of NUM_SRC sources by sel; the PC source yields
// pc + PC_INC, the memory source waits for a late mem_rvalid pulse.
// One-entry output register with valid/ready on both sides.
// Ports:
//   clk, rstn             clock (rising edge), async active-low reset
//   in_valid / in_ready   upstream handshake
//   sel, src_flat, pc     source select, packed sources, instruction PC
//   rd, reg_we            destination register and write enable
//   mem_rvalid, mem_rdata late memory read data (single-cycle pulse)
//   out_valid / out_ready downstream handshake
//   result, out_rd, out_we registered entry
//   err                   sticky error (bad select or stray mem_rvalid)
// ----------------------------------------------------------------------------
module ysyx_23060184_result_sel_stage
    import ysyx_23060184_defines::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_SRC    = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_SRC),
    parameter int PC_IDX     = RESULT_SRC_PC,
    parameter int MEM_IDX    = RESULT_SRC_MEM,
    parameter int PC_INC     = 4,
    parameter int RD_WIDTH   = 5
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SEL_WIDTH-1:0]          sel,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_flat,
    input  logic [DATA_WIDTH-1:0]         pc,
    input  logic [RD_WIDTH-1:0]           rd,
    input  logic                          reg_we,
    input  logic                          mem_rvalid,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         result,
    output logic [RD_WIDTH-1:0]           out_rd,
    output logic                          out_we,
    output logic                          err
);

    localparam logic [SEL_WIDTH-1:0] PC_SEL  = SEL_WIDTH'(PC_IDX);
    localparam logic [SEL_WIDTH-1:0] MEM_SEL = SEL_WIDTH'(MEM_IDX);

    result_state_t         state_r;
    logic [DATA_WIDTH-1:0] result_r;
    logic [RD_WIDTH-1:0]   out_rd_r;
    logic                  out_we_r;
    logic                  out_valid_r;
    logic                  err_r;

    logic [DATA_WIDTH-1:0] mux_data_s;
    logic                  mux_miss_s;
    logic [DATA_WIDTH-1:0] value_s;
    logic                  in_ready_s;
    logic                  accept_s;

    // Source selection; PC and MEM slices are overridden below.
    ysyx_23060184_mux_n #(
        .N          (NUM_SRC),
        .KEY_WIDTH  (SEL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_src_mux (
        .key       (sel),
        .data_flat (src_flat),
        .data_out  (mux_data_s),
        .miss      (mux_miss_s)
    );

    // Value for a non-memory request; the PC add wraps silently.
    always_comb begin
        if (sel == PC_SEL) begin
            value_s = pc + DATA_WIDTH'(PC_INC);
        end else begin
            value_s = mux_data_s;
        end
    end

    // Upstream handshake; held low during reset and while waiting on memory.
    always_comb begin
        in_ready_s = rstn & ((state_r == ST_IDLE)
                           | ((state_r == ST_FULL) & out_ready));
        accept_s   = in_valid & in_ready_s;
    end

    // Stage FSM with registered entry, valid and sticky error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            result_r    <= '0;
            out_rd_r    <= '0;
            out_we_r    <= 1'b0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        result_r    <= mem_rdata;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_FULL;
                    end
                end
                ST_IDLE, ST_FULL: begin
                    // A memory pulse outside WAIT_MEM has no owner.
                    if (mem_rvalid) begin
                        err_r <= 1'b1;
                    end
                    if (accept_s) begin
                        out_rd_r <= rd;
                        out_we_r <= reg_we;
                        if (mux_miss_s) begin
                            err_r <= 1'b1;
                        end
                        if (sel == MEM_SEL) begin
                            out_valid_r <= 1'b0;
                            state_r     <= ST_WAIT_MEM;
                        end else begin
                            result_r    <= value_s;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_FULL;
                        end
                    end else if ((state_r == ST_FULL) && out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign out_rd    = out_rd_r;
    assign out_we    = out_we_r;
    assign err       = err_r;

endmodule
